hazard_unit: RTL

Pipeline hazard controller for the 5-stage PCPU. It watches the ID-stage instruction and the ID/EX and EX/MEM control state. It drives the Stall input of the ID-stage control decoder, which injects a bubble, and it drives the PC / IF-ID write enables and the flush lines. It implements load-use interlock (configurable depth), taken-branch flush and jump flush, and keeps saturating stall and flush counters for performance debugging.

---
 rtl/hazard_unit_if.sv | 33 +++
 rtl/hazard_unit.sv | 122 ++++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// Hazard controller bus: ID/EX/MEM pipeline state in, stall/flush controls and perf counters out.
// Latency: purely wiring, no registers.
// Backpressure: none; the hazard unit applies backpressure through PCWrite/IFIDWrite.
interface hazard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      ifid_ins;
  logic             idex_MemtoReg;
  logic             idex_RegWrite;
  logic [4:0]       idex_Rd;
  logic             exmem_BranchTaken;
  logic             id_JUMPSrc;
  logic             Stall;
  logic             PCWrite;
  logic             IFIDWrite;
  logic             IFIDFlush;
  logic             IDEXFlush;
  logic             EXMEMFlush;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;

  // Pipeline side: presents stage state, consumes stall/flush controls.
  modport master (
    output ifid_ins, idex_MemtoReg, idex_RegWrite, idex_Rd, exmem_BranchTaken, id_JUMPSrc,
    input  Stall, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, stall_count, flush_count
  );

  // Hazard unit side.
  modport slave (
    input  ifid_ins, idex_MemtoReg, idex_RegWrite, idex_Rd, exmem_BranchTaken, id_JUMPSrc,
    output Stall, PCWrite, IFIDWrite, IFIDFlush, IDEXFlush, EXMEMFlush, stall_count, flush_count
  );
endinterface

// File: rtl/hazard_unit.sv
// Load-use interlock, taken-branch and jump flush control for the 5-stage PCPU, plus perf counters.
// Latency: controls are combinational from the current stage state; a load-use stall lasts LOAD_STALL_CYCLES.
// Backpressure: holds PC and IF/ID (PCWrite=0, IFIDWrite=0) while bubbles are injected.
module hazard_unit #(
  parameter int LOAD_STALL_CYCLES = 1,
  parameter int CNT_W             = 16
) (
  input  logic clk,
  input  logic rst,
  hazard_if.slave hz
);

  typedef enum logic {IDLE, LSTALL} state_t;

  // Remaining stall cycles after the one that detected the hazard.
  localparam logic [1:0] CNT_LOAD = 2'(LOAD_STALL_CYCLES - 1);
  localparam logic [5:0] OP_R     = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_SW    = 6'b101011;

  state_t           state_q, state_d;
  logic [1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic [5:0] op;
  logic [4:0] rs, rt;
  logic       use_rs, use_rt, hazard;
  logic       stall, pc_we, ifid_we, ifid_fl, idex_fl, exmem_fl;
  logic       unused_ins_bits;

  assign op     = hz.ifid_ins[31:26];
  assign rs     = hz.ifid_ins[25:21];
  assign rt     = hz.ifid_ins[20:16];
  // Immediate/funct bits never name a source register.
  assign unused_ins_bits = ^hz.ifid_ins[15:0];

  // Source-operand usage: J reads no rs; only R-type, SW and BEQ read rt.
  assign use_rs = (op != OP_J);
  assign use_rt = (op == OP_R) || (op == OP_SW) || (op == OP_BEQ);

  // A load in EX whose destination feeds the ID instruction; $0 never creates a dependency.
  assign hazard = hz.idex_MemtoReg && hz.idex_RegWrite && (hz.idex_Rd != 5'd0) &&
                  ((use_rs && (hz.idex_Rd == rs)) || (use_rt && (hz.idex_Rd == rt)));

  // Priority decode of branch flush > load-use stall > jump flush, with next-state; all quiet in reset.
  always_comb begin
    stall    = 1'b0;
    pc_we    = 1'b1;
    ifid_we  = 1'b1;
    ifid_fl  = 1'b0;
    idex_fl  = 1'b0;
    exmem_fl = 1'b0;
    state_d  = state_q;
    cnt_d    = cnt_q;
    if (!rst) begin
      if (hz.exmem_BranchTaken) begin
        // Wrong-path instructions in IF/ID, ID/EX and EX/MEM are discarded; any pending stall is moot.
        ifid_fl  = 1'b1;
        idex_fl  = 1'b1;
        exmem_fl = 1'b1;
        state_d  = IDLE;
        cnt_d    = 2'd0;
      end else if (state_q == LSTALL) begin
        // Hazard already covered by the first bubble; just finish the configured bubble count.
        stall   = 1'b1;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        cnt_d   = cnt_q - 2'd1;
        if (cnt_q <= 2'd1) begin
          state_d = IDLE;
        end
      end else if (hazard) begin
        stall   = 1'b1;
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        if (LOAD_STALL_CYCLES > 1) begin
          cnt_d   = CNT_LOAD;
          state_d = LSTALL;
        end
      end else if (hz.id_JUMPSrc) begin
        ifid_fl = 1'b1;
      end
    end
  end

  // FSM state and bubble counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters: stalled cycles and taken-branch flushes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
      if (hz.exmem_BranchTaken && (flush_cnt_q != '1)) begin
        flush_cnt_q <= flush_cnt_q + 1'b1;
      end
    end
  end

  assign hz.Stall       = stall;
  assign hz.PCWrite     = pc_we;
  assign hz.IFIDWrite   = ifid_we;
  assign hz.IFIDFlush   = ifid_fl;
  assign hz.IDEXFlush   = idex_fl;
  assign hz.EXMEMFlush  = exmem_fl;
  assign hz.stall_count = stall_cnt_q;
  assign hz.flush_count = flush_cnt_q;

endmodule
